det3_seq_ctrl: RTL and testbench

//  Sequenced 3x3 determinant engine for the matrix coprocessor. Computes the determinant with one signed triple-product per clock.

---
 rtl/det3_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_det3_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/det3_seq_ctrl.sv
// det3_seq_ctrl
//   Sequenced 3x3 signed determinant engine. A matrix is accepted over a
//   valid/ready handshake, the six Sarrus triple-products are accumulated
//   one per clock, and the DATA_W-bit result plus an overflow flag is held
//   on the output until the consumer accepts it.
//
//   Optional feature: define DET_SAT_EN to saturate det on overflow instead
//   of wrapping (ovf behaves the same either way).
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   matrix on m is valid
//   in_ready   engine idle, matrix will be accepted
//   m          packed a00..a22 row-major, a00 at the MSBs
//   out_valid  det/ovf valid, held until out_ready
//   out_ready  consumer accepts the result
//   det        signed determinant (wrapped or saturated)
//   ovf        true determinant outside the DATA_W signed range
//   busy       engine not idle
module det3_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32   // must be >= 3*DATA_W+3 to hold six full products
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*DATA_W-1:0]   m,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     det,
  output logic                  ovf,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

  localparam int PW = 3 * DATA_W;

  // Signed limits of the result range, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] DMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] DMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                   state_reg, state_next;
  logic signed [DATA_W-1:0] mat_reg [9];
  logic signed [DATA_W-1:0] mat_next [9];
  logic signed [DATA_W-1:0] m_elem [9];
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic [2:0]               term_reg, term_next;
  logic [DATA_W-1:0]        det_reg, det_next;
  logic                     ovf_reg, ovf_next;
  logic                     out_valid_reg, out_valid_next;

  // Unpack the input bus: element 0 (a00) sits at the top of m.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_unpack
      assign m_elem[gi] = m[(8-gi)*DATA_W +: DATA_W];
    end
  endgenerate

  // Operand selection for the current term (indices into row-major matrix).
  logic [3:0] ia, ib, ic;
  logic       neg;

  always_comb begin
    ia  = 4'd0;
    ib  = 4'd4;
    ic  = 4'd8;
    neg = 1'b0;
    case (term_reg)
      3'd0: begin ia = 4'd0; ib = 4'd4; ic = 4'd8; neg = 1'b0; end
      3'd1: begin ia = 4'd1; ib = 4'd5; ic = 4'd6; neg = 1'b0; end
      3'd2: begin ia = 4'd2; ib = 4'd3; ic = 4'd7; neg = 1'b0; end
      3'd3: begin ia = 4'd2; ib = 4'd4; ic = 4'd6; neg = 1'b1; end
      3'd4: begin ia = 4'd0; ib = 4'd5; ic = 4'd7; neg = 1'b1; end
      3'd5: begin ia = 4'd1; ib = 4'd3; ic = 4'd8; neg = 1'b1; end
      default: ;
    endcase
  end

  // Operands are widened to the full product width first so the triple
  // product is computed without any intermediate truncation.
  logic signed [PW-1:0]    pa, pb, pc, prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign pa       = {{(2*DATA_W){mat_reg[ia][DATA_W-1]}}, mat_reg[ia]};
  assign pb       = {{(2*DATA_W){mat_reg[ib][DATA_W-1]}}, mat_reg[ib]};
  assign pc       = {{(2*DATA_W){mat_reg[ic][DATA_W-1]}}, mat_reg[ic]};
  assign prod     = pa * pb * pc;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  logic ovf_calc;
  assign ovf_calc = (acc_reg > DMAX) || (acc_reg < DMIN);

`ifdef DET_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    state_next     = state_reg;
    mat_next       = mat_reg;
    acc_next       = acc_reg;
    term_next      = term_reg;
    det_next       = det_reg;
    ovf_next       = ovf_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          mat_next   = m_elem;
          acc_next   = '0;
          term_next  = 3'd0;
          state_next = MAC;
        end
      end
      MAC: begin
        acc_next  = neg ? (acc_reg - prod_ext) : (acc_reg + prod_ext);
        term_next = term_reg + 3'd1;
        if (term_reg == 3'd5) state_next = FINAL;
      end
      FINAL: begin
`ifdef DET_SAT_EN
        if (ovf_calc) det_next = acc_reg[ACC_W-1] ? SAT_MIN : SAT_MAX;
        else          det_next = acc_reg[DATA_W-1:0];
`else
        det_next = acc_reg[DATA_W-1:0];
`endif
        ovf_next       = ovf_calc;
        out_valid_next = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        // Inputs are ignored here; only the result handshake matters.
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      term_reg      <= 3'd0;
      det_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < 9; i++) mat_reg[i] <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      term_reg      <= term_next;
      det_reg       <= det_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
      mat_reg       <= mat_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign det       = det_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_det3_seq_ctrl.sv
// Bench for det3_seq_ctrl (DATA_W=8): table of matrices with known
// determinants, random matrices checked against a reference model, and
// hand-written back-pressure and mid-operation reset sequences. Expected
// results are queued on accept and compared when the result handshake fires.
module tb_det3_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] m;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  det;
  logic        ovf;
  logic        busy;

  always #5 clk = ~clk;

  det3_seq_ctrl #(.DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .det(det), .ovf(ovf), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [7:0] det; logic ovf; } exp_t;
  typedef struct { logic [71:0] m; int tdet; } vec_t;

  exp_t sb[$];
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [71:0] pk(input int e0, input int e1, input int e2,
                                     input int e3, input int e4, input int e5,
                                     input int e6, input int e7, input int e8);
    return {e0[7:0], e1[7:0], e2[7:0], e3[7:0], e4[7:0], e5[7:0], e6[7:0], e7[7:0], e8[7:0]};
  endfunction

  function automatic int det_model(input logic [71:0] mm);
    int a[9];
    for (int i = 0; i < 9; i++) a[i] = int'($signed(mm[(8-i)*8 +: 8]));
    return a[0]*a[4]*a[8] + a[1]*a[5]*a[6] + a[2]*a[3]*a[7]
         - a[2]*a[4]*a[6] - a[0]*a[5]*a[7] - a[1]*a[3]*a[8];
  endfunction

  function automatic exp_t mk_exp(input int t);
    exp_t e;
    e.ovf = (t > 127) || (t < -128);
`ifdef DET_SAT_EN
    if (e.ovf) e.det = (t > 0) ? 8'h7f : 8'h80;
    else       e.det = t[7:0];
`else
    e.det = t[7:0];
`endif
    return e;
  endfunction

  // Scoreboard consumer: compare whenever the result handshake is about to fire.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual det=%02h required none", det);
      end else begin
        e = sb.pop_front();
        chk("det", {24'd0, det}, {24'd0, e.det});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        $display("txn det=%02h ovf=%0d exp_det=%02h exp_ovf=%0d", det, ovf, e.det, e.ovf);
      end
    end
  end

  // Present a matrix and wait for it to be accepted; queues its expectation.
  task automatic accept(input logic [71:0] mat, input int tdet);
    int k;
    m        = mat;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual in_ready=0 required 1");
    end
    @(posedge clk); #1;
    sb.push_back(mk_exp(tdet));
    in_valid = 1'b0;
  endtask

  // Wait for the result, checking latency; optionally apply back-pressure.
  task automatic wait_result(input int hold);
    int   lat;
    logic ir_bad;
    logic [7:0] d0;
    logic o0;
    logic unstable;
    lat    = 0;
    ir_bad = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 7);
    chk("in_ready_low_busy", {31'd0, ir_bad}, 32'd0);
    if (hold > 0) begin
      d0 = det;
      o0 = ovf;
      unstable = 1'b0;
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        m = {$urandom, $urandom, $urandom};
        @(posedge clk); #1;
        if (det !== d0 || ovf !== o0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
          unstable = 1'b1;
      end
      chk("hold_stable", {31'd0, unstable}, 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
      chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [71:0] rm;
    int          lo, hi;

    tbl[0] = '{pk(1, 0, 0, 0, 1, 0, 0, 0, 1), 1};
    tbl[1] = '{pk(2, -1, 0, 1, 3, 2, 0, 1, 4), 24};
    tbl[2] = '{pk(10, 0, 0, 0, 10, 0, 0, 0, 10), 1000};
    tbl[3] = '{pk(-10, 0, 0, 0, 10, 0, 0, 0, 10), -1000};
    tbl[4] = '{pk(-128, 0, 0, 0, -128, 0, 0, 0, -128), -2097152};
    tbl[5] = '{pk(-128, -128, -128, -128, -128, -128, -128, -128, -128), 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    m         = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_det", {24'd0, det}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].m, tbl[i].tdet);
      wait_result(0);
    end

    // Random matrices: small-valued (mostly in range) then full range.
    for (int i = 0; i < 6; i++) begin
      lo = (i < 3) ? 4 : 128;
      hi = (i < 3) ? 4 : 127;
      for (int j = 0; j < 9; j++) begin
        int v;
        v = int'($urandom_range(0, lo + hi)) - lo;
        rm[(8-j)*8 +: 8] = v[7:0];
      end
      accept(rm, det_model(rm));
      wait_result(0);
    end

    // Back-pressure with in_valid asserted and m toggling, then a second matrix.
    out_ready = 1'b0;
    accept(tbl[1].m, tbl[1].tdet);
    wait_result(5);
    accept(tbl[3].m, tbl[3].tdet);
    wait_result(0);

    // Reset during the third MAC cycle aborts the operation.
    accept(tbl[2].m, tbl[2].tdet);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_det", {24'd0, det}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    accept(tbl[0].m, tbl[0].tdet);
    wait_result(0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
